// File: rtl/etc_lane_arbiter_pkg.sv
// Shared encodings for the ETC lane arbiter: Epass status, violation codes and
// the scheduler state encoding.
package etc_pkg;

    localparam logic [1:0] EPASS_NONE   = 2'b00;
    localparam logic [1:0] EPASS_OK     = 2'b01;
    localparam logic [1:0] EPASS_LOWBAL = 2'b10;
    localparam logic [1:0] EPASS_BLACK  = 2'b11;

    localparam logic [1:0] VIOL_NONE      = 2'b00;
    localparam logic [1:0] VIOL_OVERSPEED = 2'b01;
    localparam logic [1:0] VIOL_EPASS     = 2'b10;
    localparam logic [1:0] VIOL_TIMEOUT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DECIDE = 2'd3
    } state_e;

endpackage

// File: rtl/etc_lane_arbiter_if.sv
// Lane, datapath and barrier signals of the arbiter; master is the arbiter,
// slave is the gantry environment (lanes, datapath, barrier drivers).
interface etc_lane_arbiter_if #(
    parameter int NUM_LANES   = 4,
    parameter int WIDTH_SPEED = 14
);
    localparam int SW = $clog2(NUM_LANES);

    logic [NUM_LANES-1:0]   lane_req;
    logic [2*NUM_LANES-1:0] lane_epass;
    logic [NUM_LANES-1:0]   manual_open;
    logic                   dp_done;
    logic [WIDTH_SPEED-1:0] dp_speed;
    logic                   dp_start;
    logic [SW-1:0]          dp_lane_sel;
    logic                   busy;
    logic [NUM_LANES-1:0]   barrier;
    logic                   violation;
    logic [SW-1:0]          violation_lane;
    logic [1:0]             violation_code;

    modport master (
        input  lane_req, lane_epass, manual_open, dp_done, dp_speed,
        output dp_start, dp_lane_sel, busy, barrier, violation, violation_lane, violation_code
    );

    modport slave (
        output lane_req, lane_epass, manual_open, dp_done, dp_speed,
        input  dp_start, dp_lane_sel, busy, barrier, violation, violation_lane, violation_code
    );

endinterface

// File: rtl/etc_lane_arbiter_rr_pick.sv
// Combinational round-robin select: first eligible lane at or after ptr_i,
// wrapping modulo NUM_LANES.
module etc_rr_pick #(
    parameter int NUM_LANES = 4
) (
    input  logic [NUM_LANES-1:0]         eligible_i,
    input  logic [$clog2(NUM_LANES)-1:0] ptr_i,
    output logic [$clog2(NUM_LANES)-1:0] idx_o,
    output logic                         valid_o
);
    localparam int SW = $clog2(NUM_LANES);

    logic [SW-1:0] cand [NUM_LANES];

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_cand
            assign cand[gi] = SW'((int'(ptr_i) + gi) % NUM_LANES);
        end
    endgenerate

    // Scan from the farthest offset down so the closest eligible lane wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (eligible_i[cand[k]]) begin
                idx_o   = cand[k];
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/etc_lane_arbiter.sv
// Round-robin owner of the shared speed datapath; judges each measured vehicle
// against its Epass status and drives per-lane barrier hold timers.
module etc_lane_arbiter
    import etc_pkg::*;
#(
    parameter int                     NUM_LANES    = 4,
    parameter int                     WIDTH_SPEED  = 14,
    parameter logic [WIDTH_SPEED-1:0] SPEED_LIMIT  = 14'd80,
    parameter int                     TIMEOUT      = 50_000_000,
    parameter int                     BARRIER_HOLD = 150_000_000
) (
    input logic               clk,
    input logic               reset_n,
    etc_lane_arbiter_if.master bus
);
    localparam int SW = $clog2(NUM_LANES);
    localparam int TW = $clog2(TIMEOUT);
    localparam int HW = $clog2(BARRIER_HOLD + 1);

    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(BARRIER_HOLD);
    localparam logic [SW-1:0] LAST_LANE = SW'(NUM_LANES - 1);

    state_e                 state_q, state_d;
    logic [SW-1:0]          sel_q, sel_d;
    logic [SW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [NUM_LANES-1:0]   served_q, served_d;
    logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
    logic [WIDTH_SPEED-1:0] speed_q, speed_d;

    logic                   dp_start_q;
    logic                   busy_q;
    logic                   violation_q;
    logic [SW-1:0]          violation_lane_q;
    logic [1:0]             violation_code_q;
    logic [NUM_LANES-1:0]   barrier_q, barrier_d;

    logic                   viol_d;
    logic [1:0]             viol_code_d;
    logic                   hold_load;
    logic [NUM_LANES-1:0]   eligible;
    logic [SW-1:0]          pick_idx;
    logic                   pick_valid;
    logic [SW-1:0]          next_lane;
    logic [1:0]             sel_epass;

    assign eligible  = bus.lane_req & ~served_q;
    assign next_lane = (sel_q == LAST_LANE) ? '0 : sel_q + 1'b1;
    assign sel_epass = bus.lane_epass[{sel_q, 1'b0} +: 2];

    etc_rr_pick #(.NUM_LANES(NUM_LANES)) u_pick (
        .eligible_i (eligible),
        .ptr_i      (rr_ptr_q),
        .idx_o      (pick_idx),
        .valid_o    (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        tmo_cnt_d   = tmo_cnt_q;
        speed_d     = speed_q;
        viol_d      = 1'b0;
        viol_code_d = VIOL_NONE;
        hold_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the last allowed cycle still counts.
                if (bus.dp_done) begin
                    speed_d  = bus.dp_speed;
                    rr_ptr_d = next_lane;
                    state_d  = ST_DECIDE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    viol_d      = 1'b1;
                    viol_code_d = VIOL_TIMEOUT;
                    rr_ptr_d    = next_lane;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_DECIDE: begin
                if (sel_epass != EPASS_OK) begin
                    viol_d      = 1'b1;
                    viol_code_d = VIOL_EPASS;
                end else if (speed_q > SPEED_LIMIT) begin
                    viol_d      = 1'b1;
                    viol_code_d = VIOL_OVERSPEED;
                end else begin
                    hold_load = 1'b1;
                end
                rr_ptr_d = next_lane;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [HW-1:0] hold_q, hold_d;

            // served stays set for as long as the same vehicle keeps the zone occupied
            assign served_d[gi] = bus.lane_req[gi] &
                                  (served_q[gi] | ((state_q == ST_GRANT) && (sel_q == SW'(gi))));

            always_comb begin
                hold_d = hold_q;
                if (hold_load && (sel_q == SW'(gi))) begin
                    hold_d = HOLD_LOAD;
                end else if ((hold_q != '0) && !eligible[gi]) begin
                    hold_d = hold_q - 1'b1;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    hold_q <= '0;
                end else begin
                    hold_q <= hold_d;
                end
            end

            assign barrier_d[gi] = bus.manual_open[gi] | (hold_d != '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            sel_q            <= '0;
            rr_ptr_q         <= '0;
            served_q         <= '0;
            tmo_cnt_q        <= '0;
            speed_q          <= '0;
            dp_start_q       <= 1'b0;
            busy_q           <= 1'b0;
            violation_q      <= 1'b0;
            violation_lane_q <= '0;
            violation_code_q <= VIOL_NONE;
            barrier_q        <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            served_q    <= served_d;
            tmo_cnt_q   <= tmo_cnt_d;
            speed_q     <= speed_d;
            dp_start_q  <= (state_q == ST_GRANT);
            busy_q      <= (state_d != ST_IDLE);
            violation_q <= viol_d;
            barrier_q   <= barrier_d;
            if (viol_d) begin
                violation_lane_q <= sel_q;
                violation_code_q <= viol_code_d;
            end
        end
    end

    assign bus.dp_start       = dp_start_q;
    assign bus.dp_lane_sel    = sel_q;
    assign bus.busy           = busy_q;
    assign bus.barrier        = barrier_q;
    assign bus.violation      = violation_q;
    assign bus.violation_lane = violation_lane_q;
    assign bus.violation_code = violation_code_q;

endmodule

// File: tb/tb_etc_lane_arbiter.sv
// Scenario bench for etc_lane_arbiter: expected outcomes are queued when the
// datapath result is driven and checked when the arbiter reacts.
module tb_etc_lane_arbiter;
    import etc_pkg::*;

    localparam int NL   = 4;
    localparam int WS   = 14;
    localparam int TMO  = 20;
    localparam int HOLD = 10;

    logic clk = 1'b0;
    logic reset_n;

    etc_lane_arbiter_if #(.NUM_LANES(NL), .WIDTH_SPEED(WS)) bus ();

    etc_lane_arbiter #(
        .NUM_LANES    (NL),
        .WIDTH_SPEED  (WS),
        .SPEED_LIMIT  (14'd80),
        .TIMEOUT      (TMO),
        .BARRIER_HOLD (HOLD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lane;
        logic [1:0] code;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [1:0] model_code(input logic [1:0] ep, input int speed);
        if (ep != 2'b01) return 2'b10;
        if (speed > 80) return 2'b01;
        return 2'b00;
    endfunction

    task automatic wait_start(output int lat, output int lane);
        lat  = -1;
        lane = -1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.dp_start === 1'b1) begin
                lat  = c;
                lane = int'(bus.dp_lane_sel);
            end
        end
    endtask

    // Called on the negedge where dp_start is seen; returns on the negedge two
    // cycles after dp_done, when the verdict is visible.
    task automatic pulse_done(input int speed);
        bus.dp_speed = WS'(speed);
        bus.dp_done  = 1'b1;
        @(negedge clk);
        bus.dp_done  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus.dp_start, bus.busy, bus.violation, bus.violation_code, bus.dp_lane_sel,
             bus.violation_lane, bus.barrier} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: start=%b busy=%b viol=%b code=%b sel=%0d vlane=%0d barrier=%b, want all 0",
                     bus.dp_start, bus.busy, bus.violation, bus.violation_code, bus.dp_lane_sel,
                     bus.violation_lane, bus.barrier);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.dp_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b start=%b, want 0 0", bus.busy, bus.dp_start);
        end
    endtask

    task automatic test_single_pass();
        int   lat, lane, cnt;
        exp_t e;
        bus.lane_epass[5:4] = EPASS_OK;
        bus.lane_req[2]     = 1'b1;
        wait_start(lat, lane);
        n_cmp++;
        if (lat != 2 || lane != 2) begin
            n_err++;
            $display("FAIL single_start: latency=%0d lane=%0d, want latency=2 lane=2", lat, lane);
        end
        if (lat > 0) begin
            sb.push_back('{2, model_code(EPASS_OK, 60)});
            pulse_done(60);
            e = sb.pop_front();
            n_cmp++;
            if (bus.violation !== (e.code != 2'b00) || bus.barrier[e.lane] !== (e.code == 2'b00)) begin
                n_err++;
                $display("FAIL single_verdict: viol=%b barrier=%b, want code=%b lane=%0d",
                         bus.violation, bus.barrier, e.code, e.lane);
            end
            cnt = (bus.barrier[2] === 1'b1) ? 1 : 0;
            for (int c = 0; c < 30 && cnt > 0; c++) begin
                @(negedge clk);
                if (bus.barrier[2] === 1'b1) cnt++;
                else break;
            end
            n_cmp++;
            if (cnt != HOLD) begin
                n_err++;
                $display("FAIL single_hold: barrier[2] open %0d cycles, want %0d", cnt, HOLD);
            end
        end
        bus.lane_req[2] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_overspeed();
        int   lat, lane;
        exp_t e;
        bus.lane_epass[1:0] = EPASS_OK;
        bus.lane_req[0]     = 1'b1;
        wait_start(lat, lane);
        n_cmp++;
        if (lat < 0 || lane != 0) begin
            n_err++;
            $display("FAIL overspeed_start: latency=%0d lane=%0d, want a start on lane 0", lat, lane);
        end
        if (lat > 0) begin
            sb.push_back('{0, model_code(EPASS_OK, 81)});
            pulse_done(81);
            e = sb.pop_front();
            n_cmp++;
            if (bus.violation !== 1'b1 || bus.violation_code !== e.code ||
                int'(bus.violation_lane) != e.lane || bus.barrier[0] !== 1'b0) begin
                n_err++;
                $display("FAIL overspeed_verdict: viol=%b code=%b lane=%0d barrier=%b, want 1 %b %0d barrier0=0",
                         bus.violation, bus.violation_code, bus.violation_lane, bus.barrier, e.code, e.lane);
            end
            @(negedge clk);
            n_cmp++;
            if (bus.violation !== 1'b0 || bus.barrier[0] !== 1'b0) begin
                n_err++;
                $display("FAIL overspeed_pulse: viol=%b barrier0=%b one cycle later, want 0 0",
                         bus.violation, bus.barrier[0]);
            end
        end
        bus.lane_req[0] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        int   lat, lane, exp_lane, extra;
        int   order[$];
        int   speeds[3] = '{80, 79, 60};
        exp_t e;
        order = '{1, 3, 0};
        bus.lane_epass = {EPASS_OK, EPASS_OK, EPASS_OK, EPASS_OK};
        bus.lane_req   = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            wait_start(lat, lane);
            exp_lane = order.pop_front();
            n_cmp++;
            if (lat < 0 || lane != exp_lane) begin
                n_err++;
                $display("FAIL rr_order[%0d]: lane=%0d latency=%0d, want lane %0d", k, lane, lat, exp_lane);
            end
            if (lat > 0) begin
                sb.push_back('{lane, model_code(EPASS_OK, speeds[k])});
                pulse_done(speeds[k]);
                e = sb.pop_front();
                n_cmp++;
                if (bus.violation !== (e.code != 2'b00) || bus.barrier[e.lane] !== (e.code == 2'b00)) begin
                    n_err++;
                    $display("FAIL rr_verdict[%0d]: viol=%b code=%b barrier=%b, want code=%b lane=%0d open",
                             k, bus.violation, bus.violation_code, bus.barrier, e.code, e.lane);
                end
            end
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.dp_start === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL rr_single_service: %0d extra dp_start pulses, want 0", extra);
        end
        bus.lane_req = '0;
        repeat (15) @(negedge clk);
        n_cmp++;
        if (bus.barrier !== '0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL rr_drain: barrier=%b busy=%b, want 0000 0", bus.barrier, bus.busy);
        end
    endtask

    task automatic test_bad_epass();
        int   lat, lane;
        exp_t e;
        bus.lane_epass[3:2] = EPASS_BLACK;
        bus.lane_req[1]     = 1'b1;
        wait_start(lat, lane);
        n_cmp++;
        if (lat < 0 || lane != 1) begin
            n_err++;
            $display("FAIL epass_start: latency=%0d lane=%0d, want a start on lane 1", lat, lane);
        end
        if (lat > 0) begin
            sb.push_back('{1, model_code(EPASS_BLACK, 40)});
            pulse_done(40);
            e = sb.pop_front();
            n_cmp++;
            if (bus.violation !== 1'b1 || bus.violation_code !== e.code ||
                int'(bus.violation_lane) != e.lane || bus.barrier[1] !== 1'b0) begin
                n_err++;
                $display("FAIL epass_verdict: viol=%b code=%b lane=%0d barrier=%b, want 1 %b %0d barrier1=0",
                         bus.violation, bus.violation_code, bus.violation_lane, bus.barrier, e.code, e.lane);
            end
        end
        bus.lane_req[1]     = 1'b0;
        bus.lane_epass[3:2] = EPASS_OK;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int   lat, lane, cnt, bad;
        exp_t e;
        bus.lane_epass[5:4] = EPASS_OK;
        bus.lane_req[2]     = 1'b1;
        wait_start(lat, lane);
        n_cmp++;
        if (lat < 0 || lane != 2) begin
            n_err++;
            $display("FAIL timeout_start: latency=%0d lane=%0d, want a start on lane 2", lat, lane);
        end
        if (lat > 0) begin
            sb.push_back('{2, VIOL_TIMEOUT});
            cnt = -1;
            for (int c = 1; c <= 40 && cnt < 0; c++) begin
                @(negedge clk);
                if (bus.violation === 1'b1) cnt = c;
            end
            e = sb.pop_front();
            n_cmp++;
            if (cnt != TMO || bus.violation_code !== e.code || int'(bus.violation_lane) != e.lane ||
                bus.busy !== 1'b0 || bus.barrier[2] !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_verdict: after %0d cycles code=%b lane=%0d busy=%b barrier=%b, want %0d %b %0d busy0",
                         cnt, bus.violation_code, bus.violation_lane, bus.busy, bus.barrier, TMO, e.code, e.lane);
            end
            bad = 0;
            bus.dp_speed = WS'(30);
            bus.dp_done  = 1'b1;
            @(negedge clk);
            bus.dp_done  = 1'b0;
            repeat (3) begin
                if (bus.violation === 1'b1 || bus.busy === 1'b1 || bus.barrier[2] === 1'b1 ||
                    bus.dp_start === 1'b1) bad++;
                @(negedge clk);
            end
            n_cmp++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL timeout_late_done: %0d cycles reacted to a late dp_done, want 0", bad);
            end
        end
        bus.lane_req[2] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int   lat, lane, starts, viols;
        exp_t e;
        bus.lane_epass = {EPASS_OK, EPASS_OK, EPASS_OK, EPASS_OK};
        bus.lane_req[3] = 1'b1;
        wait_start(lat, lane);
        if (lat > 0) begin
            sb.push_back('{3, model_code(EPASS_OK, 30)});
            pulse_done(30);
            e = sb.pop_front();
            n_cmp++;
            if (bus.violation !== 1'b0 || bus.barrier[e.lane] !== 1'b1) begin
                n_err++;
                $display("FAIL rst_pass_lane3: viol=%b barrier=%b, want barrier3 open", bus.violation, bus.barrier);
            end
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL rst_start_lane3: no dp_start within bound, want one");
        end
        bus.lane_req[0] = 1'b1;
        wait_start(lat, lane);
        n_cmp++;
        if (lat < 0 || lane != 0 || bus.barrier[3] !== 1'b1 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_setup: lane=%0d latency=%0d barrier=%b busy=%b, want lane 0 waiting with barrier3 open",
                     lane, lat, bus.barrier, bus.busy);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.dp_start, bus.busy, bus.violation, bus.violation_code, bus.dp_lane_sel,
             bus.violation_lane, bus.barrier} !== '0) begin
            n_err++;
            $display("FAIL rst_async: start=%b busy=%b viol=%b code=%b sel=%0d vlane=%0d barrier=%b, want all 0",
                     bus.dp_start, bus.busy, bus.violation, bus.violation_code, bus.dp_lane_sel,
                     bus.violation_lane, bus.barrier);
        end
        bus.lane_req[3] = 1'b0;
        @(negedge clk);
        reset_n      = 1'b1;
        bus.dp_speed = WS'(30);
        bus.dp_done  = 1'b1;
        @(negedge clk);
        bus.dp_done  = 1'b0;
        starts = 0;
        viols  = 0;
        repeat (100) begin
            if (bus.dp_start === 1'b1) starts++;
            if (bus.violation === 1'b1) begin
                viols++;
                if (bus.violation_code !== VIOL_TIMEOUT) viols += 10;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (starts != 1 || viols != 1) begin
            n_err++;
            $display("FAIL rst_single_service: starts=%0d violation score=%0d, want 1 start and 1 timeout",
                     starts, viols);
        end
        bus.lane_req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n         = 1'b0;
        bus.lane_req    = '0;
        bus.lane_epass  = '0;
        bus.manual_open = '0;
        bus.dp_done     = 1'b0;
        bus.dp_speed    = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single_pass();
        test_overspeed();
        test_round_robin();
        test_bad_epass();
        test_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/etc_lane_arbiter.md
# etc_lane_arbiter

Round-robin scheduler that shares one speed-measurement datapath among `NUM_LANES` toll lanes of the non-stop ETC gantry. It grants the datapath to one requesting lane at a time, issues the start strobe and waits for the result. It then combines the measured speed with that lane's Epass status to open or keep closed the lane barrier. Per-lane barrier hold timers and manual-override inputs sit here, so the shared datapath stays single-lane.

## Interface
- `NUM_LANES`, 4: number of lanes, 2..8.
- `WIDTH_SPEED`, 14: width of the datapath speed result.
- `SPEED_LIMIT`, 14'd80: maximum speed that still opens the barrier; the comparison is inclusive.
- `TIMEOUT`, 50_000_000: cycles to wait for `dp_done` before the measurement is aborted.
- `BARRIER_HOLD`, 150_000_000: cycles the barrier stays open after a pass.

- `clk` in 1: system clock, the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `lane_req` in NUM_LANES: level; high while a vehicle occupies the lane's sensor1 zone.
- `lane_epass` in 2*NUM_LANES: lane i uses bits [2i+1:2i]. 00 = no tag, 01 = valid, 10 = low balance, 11 = blacklisted.
- `manual_open` in NUM_LANES: operator override; forces that lane's barrier open.
- `dp_done` in 1: one-cycle pulse from the datapath when the result is ready.
- `dp_speed` in WIDTH_SPEED: datapath result, sampled only when `dp_done` is high.
- `dp_start` out 1: one-cycle start strobe to the datapath.
- `dp_lane_sel` out $clog2(NUM_LANES): lane currently owning the datapath; drives the sensor mux.
- `busy` out 1: high in every state except IDLE.
- `barrier` out NUM_LANES: 1 = barrier open.
- `violation` out 1: one-cycle pulse on a refused vehicle.
- `violation_lane` out $clog2(NUM_LANES): lane index qualified by `violation`.
- `violation_code` out 2: 01 = overspeed, 10 = bad Epass, 11 = timeout.

## Operation
- FSM states are IDLE, GRANT, WAIT, DECIDE.
- A lane is eligible when `lane_req[i]` is high and `served[i]` is low.
- IDLE: if any lane is eligible, pick the first eligible lane at or after `rr_ptr`, wrapping modulo NUM_LANES. Latch it into `dp_lane_sel`, then go to GRANT.
- GRANT (one cycle): assert `dp_start`, clear the timeout counter, set `served[sel]`, go to WAIT.
- WAIT: on `dp_done`, capture `dp_speed` and go to DECIDE. If the timeout counter reaches TIMEOUT-1 first, pulse `violation` with code 11 and go to IDLE.
- DECIDE (one cycle) evaluates in this priority order:
  - If the Epass field for `sel` is not 01, pulse `violation` with code 10.
  - Otherwise, if speed > SPEED_LIMIT, pulse `violation` with code 01.
  - Otherwise, load `hold_cnt[sel]` with BARRIER_HOLD.
  - Then go to IDLE.
- `rr_ptr` becomes `sel`+1 (wrapping) on exit from WAIT or DECIDE.
- `served[i]` clears whenever `lane_req[i]` is low. A vehicle is serviced once per presence.
- If `lane_req[sel]` drops during WAIT, the measurement still completes and is judged normally.
- Barrier output: `barrier[i]` = `manual_open[i]` OR (`hold_cnt[i]` != 0).
- `hold_cnt[i]` decrements each cycle while nonzero. While `lane_req[i]` is high and `served[i]` is low (a new vehicle arrives), the count freezes rather than expiring mid-pass.
- Simultaneous `dp_done` and timeout: `dp_done` wins.
- `dp_done` outside WAIT is ignored.
- Manual override does not bypass arbitration. The lane is still measured and violations are still reported.

## Timing
- All outputs are registered.
- Reset values: FSM = IDLE; `dp_start`, `busy`, `violation`, `barrier`, `violation_code` = 0. `dp_lane_sel`, `violation_lane`, `rr_ptr`, `served`, `hold_cnt` = 0.
- Latency:
  - `lane_req` rising edge (lane idle) → `dp_start` 2 cycles later.
  - `dp_done` → `barrier` high or `violation` pulse 2 cycles later.
- Exactly one `dp_start` per grant. `dp_lane_sel` is stable from GRANT through DECIDE.
- Reset mid-WAIT: the FSM returns to IDLE immediately, barriers close, and a later stray `dp_done` is ignored.
- Counter widths: $clog2(TIMEOUT) and $clog2(BARRIER_HOLD+1); no wrap is permitted.

## Structure
- Package `etc_pkg`:
  - Epass encodings: EPASS_NONE, EPASS_OK, EPASS_LOWBAL, EPASS_BLACK.
  - Violation codes.
  - FSM state enum.
- One sub-module, `etc_rr_pick`: combinational round-robin priority select. Inputs are the eligible vector and the pointer; outputs are the index and a valid flag.
- Per-lane hold counters are a generate loop inside the top.

## Test plan
- NUM_LANES=4, TIMEOUT=20, BARRIER_HOLD=10. Lane 2 requests with Epass 01 and speed 60 → `dp_start` with sel=2 at +2 cycles; `barrier[2]` high for exactly 10 cycles, then low.
- Lanes 0, 1 and 3 request in the same cycle with `rr_ptr`=1 → service order 1, 3, 0; one `dp_start` each.
- Lane 0 with Epass 01 and speed 81 → `violation`=1, code 01, lane 0; `barrier[0]` stays 0.
- Lane 1 with Epass 11 and speed 40 → code 10; barrier stays closed.
- No `dp_done` for 20 cycles → code 11; FSM in IDLE; a late `dp_done` is ignored.
- Assert `reset_n` low during WAIT while `barrier[3]` is open → all outputs return to their reset values asynchronously. Holding `lane_req[0]` high for 100 cycles produces only one service.
